// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry skid-buffered issue stage that precomputes ALU operands and op encoding at acceptance (optional operand forwarding under ALU_ISSUE_FORWARD_EN)
module alu_issue_stage #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_rs1_data,
  input  logic [WORD_SIZE-1:0] in_rs2_data,
  input  logic [WORD_SIZE-1:0] in_pc,
  input  logic [WORD_SIZE-1:0] in_imm,
  input  logic [4:0]           in_rs1_addr,
  input  logic [4:0]           in_rs2_addr,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_funct3,
  input  logic                 in_funct7_5,
  input  logic [1:0]           in_kind,
`ifdef ALU_ISSUE_FORWARD_EN
  input  logic                 fwd_valid,
  input  logic [4:0]           fwd_rd,
  input  logic [WORD_SIZE-1:0] fwd_data,
`endif
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_op,
  output logic [4:0]           out_rd
);
  localparam int EW = 2 * WORD_SIZE + 9;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_main, r_skid, w_new;
  logic [WORD_SIZE-1:0] w_src1, w_src2, w_rs1, w_rs2, w_a, w_braw, w_b;
  logic [2:0] w_op3;
  logic w_inv, w_acc, w_deq;
`ifdef ALU_ISSUE_FORWARD_EN
  assign w_src1 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs1_addr) ? fwd_data : in_rs1_data;
  assign w_src2 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs2_addr) ? fwd_data : in_rs2_data;
`else
  assign w_src1 = in_rs1_data;
  assign w_src2 = in_rs2_data;
`endif
  assign w_rs1 = (in_rs1_addr == 5'd0) ? '0 : w_src1;
  assign w_rs2 = (in_rs2_addr == 5'd0) ? '0 : w_src2;
  assign w_op3 = in_kind[1] ? 3'd0 : in_funct3;
  assign w_inv = in_funct7_5 && ((in_kind == 2'd0) ? (in_funct3 == 3'd0 || in_funct3 == 3'd5)
                                                    : (in_kind == 2'd1 && in_funct3 == 3'd5));
  assign w_a = (in_kind == 2'd2) ? in_pc : (in_kind == 2'd3) ? '0 : w_rs1;
  assign w_braw = (in_kind == 2'd0) ? w_rs2 : in_imm;
  assign w_b = (w_op3 == 3'd1 || w_op3 == 3'd5) ? {{(WORD_SIZE-5){1'b0}}, w_braw[4:0]} : w_braw;
  assign w_new = {w_a, w_b, w_inv, w_op3, in_rd};
  assign w_acc = in_valid && in_ready;
  assign w_deq = out_valid && out_ready;
  assign {alu_a, alu_b, alu_op, out_rd} = r_main;
  // buffer occupancy register
  always_ff @(posedge clk)
    r_state <= !rst_n ? EMPTY : w_next;
  // occupancy transitions; flush overrides any transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc && !w_deq) ? FULL : (!w_acc && w_deq) ? EMPTY : ONE;
      FULL:    w_next = w_deq ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
    if (flush) w_next = EMPTY;
  end
  // handshake outputs decoded from registered occupancy only
  always_comb begin
    in_ready  = r_state != FULL;
    out_valid = r_state != EMPTY;
  end
  // main entry drives the outputs; skid holds the second instruction while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      if (r_state == FULL && w_deq) r_main <= r_skid;
      else if (w_acc && (r_state == EMPTY || w_deq)) r_main <= w_new;
      if (w_acc && r_state == ONE && !w_deq) r_skid <= w_new;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a queue-based reference model
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_funct7_5, flush, out_valid, out_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm, alu_a, alu_b;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd, out_rd;
  logic [2:0] in_funct3;
  logic [1:0] in_kind;
  logic [3:0] alu_op;
`ifdef ALU_ISSUE_FORWARD_EN
  logic fwd_valid;
  logic [4:0] fwd_rd;
  logic [31:0] fwd_data;
`endif
  logic [72:0] q[$];
  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_kind(in_kind),
`ifdef ALU_ISSUE_FORWARD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] v;
    v = data;
`ifdef ALU_ISSUE_FORWARD_EN
    if (fwd_valid && fwd_rd != 0 && fwd_rd == addr) v = fwd_data;
`endif
    return (addr == 0) ? 32'd0 : v;
  endfunction

  function automatic logic [72:0] ref_entry();
    logic [31:0] s1, s2, a, b;
    logic [2:0] op;
    logic inv;
    s1 = src(in_rs1_addr, in_rs1_data);
    s2 = src(in_rs2_addr, in_rs2_data);
    a = s1; b = in_imm; op = in_funct3; inv = 1'b0;
    if (in_kind == 0) begin
      b = s2;
      inv = in_funct7_5 && (in_funct3 == 0 || in_funct3 == 5);
    end else if (in_kind == 1) begin
      inv = in_funct7_5 && in_funct3 == 5;
    end else begin
      a = (in_kind == 2) ? in_pc : 32'd0;
      op = 3'd0;
    end
    if (op == 1 || op == 5) b = b % 32;
    return {a, b, inv, op, in_rd};
  endfunction

  task automatic tick();
    bit acc, deq, rst_was;
    logic [72:0] e;
    acc = in_valid && q.size() < 2;
    deq = q.size() > 0 && out_ready;
    rst_was = !rst_n;
    e = ref_entry();
    @(posedge clk);
    if (!rst_n || flush) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    if (q.size() > 0) chk("payload", 128'({alu_a, alu_b, alu_op, out_rd}), 128'(q[0]));
    if (rst_was) chk("reset_payload", 128'({alu_a, alu_b, alu_op, out_rd}), 128'd0);
  endtask

  task automatic set_instr(input logic [1:0] kind, input logic [2:0] f3, input logic f7,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                           input logic [4:0] rd);
    in_kind = kind; in_funct3 = f3; in_funct7_5 = f7;
    in_rs1_addr = 5'd1; in_rs2_addr = 5'd2; in_rs1_data = r1; in_rs2_data = r2;
    in_imm = imm; in_pc = 32'h1000; in_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_instr(2'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
`ifdef ALU_ISSUE_FORWARD_EN
    fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    set_instr(2'd0, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 5'd7);
    in_valid = 1'b1;
    tick();
    chk("sub_a", 128'(alu_a), 128'd10);
    chk("sub_b", 128'(alu_b), 128'd3);
    chk("sub_op", 128'(alu_op), 128'h8);
    set_instr(2'd1, 3'd0, 1'b1, 32'd4, 32'd0, 32'hFFFF_FFFF, 5'd8);
    tick();
    chk("addi_op", 128'(alu_op), 128'h0);
    chk("addi_b", 128'(alu_b), 128'hFFFF_FFFF);
    set_instr(2'd1, 3'd5, 1'b1, 32'd4, 32'd0, 32'h4000_0405, 5'd9);
    tick();
    chk("srai_op", 128'(alu_op), 128'hD);
    chk("srai_b", 128'(alu_b), 128'd5);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_rd = 5'(i);
      tick();
    end
    chk("stall_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("order_1", 128'(out_rd), 128'd1);
    tick();
    chk("order_2", 128'(out_rd), 128'd2);
    tick();
    chk("drained", 128'(out_valid), 128'd0);
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    chk("flush_valid", 128'(out_valid), 128'd0);
    chk("flush_ready", 128'(in_ready), 128'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_nothing", 128'(out_valid), 128'd0);
    in_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
`ifdef ALU_ISSUE_FORWARD_EN
    set_instr(2'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd3);
    in_rs1_addr = 5'd5; fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h1234; in_valid = 1'b1;
    tick();
    chk("fwd_hit", 128'(alu_a), 128'h1234);
    in_rs1_addr = 5'd0; fwd_rd = 5'd0;
    tick();
    chk("fwd_zero", 128'(alu_a), 128'd0);
    fwd_valid = 1'b0; in_valid = 1'b0;
`endif
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      flush = $urandom_range(0, 15) == 0;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      in_kind = 2'($urandom_range(0, 3));
      in_funct3 = 3'($urandom);
      in_funct7_5 = 1'($urandom);
      in_rs1_addr = 5'($urandom_range(0, 3));
      in_rs2_addr = 5'($urandom_range(0, 3));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_pc = $urandom;
      in_imm = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_rd = 5'($urandom);
`ifdef ALU_ISSUE_FORWARD_EN
      fwd_valid = 1'($urandom_range(0, 1));
      fwd_rd = 5'($urandom_range(0, 3));
      fwd_data = $urandom;
`endif
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
